// File: rtl/prog_down_counter.sv
// Programmable down-counter with a reload register, one-shot or auto-reload operation,
// a registered terminal-count pulse and a combinational cascade borrow.
module prog_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET_n,
    input  logic             LOAD_n,
    input  logic [WIDTH-1:0] D,
    input  logic             START,
    input  logic             EN,
    input  logic             MODE,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             BUSY,
    output logic             BORROW_n
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] rld;
    logic [WIDTH-1:0] rld_next;
    logic [WIDTH-1:0] q_next;
    logic             tc_next;
    logic             at_zero;
    logic             count_step;

    assign at_zero    = (Q == '0);
    assign count_step = (state == RUN) && EN;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Priority: load > start > terminal event > hold.
    always_comb begin
        // NOTE: default first so no path through this block can infer a latch.
        state_next = state;
        if (!LOAD_n) begin
            state_next = IDLE;
        end else if (START) begin
            state_next = RUN;
        end else if (count_step && at_zero && !MODE) begin
            state_next = IDLE;
        end
    end

    // MODE only matters at the zero event; elsewhere it is ignored.
    always_comb begin
        rld_next = rld;
        q_next   = Q;
        tc_next  = 1'b0;
        if (!LOAD_n) begin
            rld_next = D;
            q_next   = D;
        end else if (START) begin
            q_next = rld;
        end else if (count_step) begin
            if (at_zero) begin
                tc_next = 1'b1;
                q_next  = MODE ? rld : '0;
            end else begin
                q_next = Q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            rld <= '0;
            Q   <= '0;
            TC  <= 1'b0;
        end else begin
            rld <= rld_next;
            Q   <= q_next;
            TC  <= tc_next;
        end
    end

    // BUSY comes straight off the state flop; BORROW_n is the combinational cascade output.
    always_comb begin
        BUSY     = (state == RUN);
        BORROW_n = !((state == RUN) && EN && at_zero);
    end

endmodule

// File: tb/tb_prog_down_counter.sv
// Table-driven bench for prog_down_counter: vectors are queued as expectations when driven
// and compared after the following rising edge; reset behaviour is exercised by hand.
module tb_prog_down_counter;

    localparam int WIDTH = 8;

    logic             CLK;
    logic             RESET_n;
    logic             LOAD_n;
    logic [WIDTH-1:0] D;
    logic             START;
    logic             EN;
    logic             MODE;
    logic [WIDTH-1:0] Q;
    logic             TC;
    logic             BUSY;
    logic             BORROW_n;

    prog_down_counter #(.WIDTH(WIDTH)) dut (
        .CLK      (CLK),
        .RESET_n  (RESET_n),
        .LOAD_n   (LOAD_n),
        .D        (D),
        .START    (START),
        .EN       (EN),
        .MODE     (MODE),
        .Q        (Q),
        .TC       (TC),
        .BUSY     (BUSY),
        .BORROW_n (BORROW_n)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic             load_n;
        logic [WIDTH-1:0] d;
        logic             start;
        logic             en;
        logic             mode;
        logic [WIDTH-1:0] q;
        logic             tc;
        logic             busy;
        logic             borrow_n;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             tc;
        logic             busy;
        logic             borrow_n;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic ld, input int d, input logic st, input logic en,
                                input logic md, input int q, input logic tc, input logic busy,
                                input logic bn);
        vec_t v;
        v.load_n = ld; v.d = WIDTH'(d); v.start = st; v.en = en; v.mode = md;
        v.q = WIDTH'(q); v.tc = tc; v.busy = busy; v.borrow_n = bn;
        vecs.push_back(v);
    endfunction

    // Drive on the falling edge, queue the expectation, compare just after the rising edge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        @(negedge CLK);
        LOAD_n = v.load_n; D = v.d; START = v.start; EN = v.en; MODE = v.mode;
        e.q = v.q; e.tc = v.tc; e.busy = v.busy; e.borrow_n = v.borrow_n;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        check({tag, " Q"},        32'(Q),        32'(e.q));
        check({tag, " TC"},       32'(TC),       32'(e.tc));
        check({tag, " BUSY"},     32'(BUSY),     32'(e.busy));
        check({tag, " BORROW_n"}, 32'(BORROW_n), 32'(e.borrow_n));
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("%s[%0d]", name, i));
        end
        vecs.delete();
    endtask

    initial begin
        RESET_n = 1'b0; LOAD_n = 1'b1; D = '0; START = 1'b0; EN = 1'b1; MODE = 1'b0;
        #2;
        check("reset Q",        32'(Q),        32'd0);
        check("reset TC",       32'(TC),       32'd0);
        check("reset BUSY",     32'(BUSY),     32'd0);
        check("reset BORROW_n", 32'(BORROW_n), 32'd1);
        @(negedge CLK);
        RESET_n = 1'b1;

        //   ld d  st en md   q  tc busy bn
        add(0, 3, 0, 1, 0,   3, 0, 0, 1);
        add(1, 0, 1, 1, 0,   3, 0, 1, 1);
        add(1, 0, 0, 1, 0,   2, 0, 1, 1);
        add(1, 0, 0, 1, 0,   1, 0, 1, 1);
        add(1, 0, 0, 1, 0,   0, 0, 1, 0);
        add(1, 0, 0, 1, 0,   0, 1, 0, 1);
        add(1, 0, 0, 1, 0,   0, 0, 0, 1);
        add(1, 0, 0, 1, 0,   0, 0, 0, 1);
        run_table("oneshot");

        add(0, 2, 0, 1, 1,   2, 0, 0, 1);
        add(1, 0, 1, 1, 1,   2, 0, 1, 1);
        add(1, 0, 0, 1, 1,   1, 0, 1, 1);
        add(1, 0, 0, 1, 1,   0, 0, 1, 0);
        add(1, 0, 0, 1, 1,   2, 1, 1, 1);
        add(1, 0, 0, 1, 0,   1, 0, 1, 1);
        add(1, 0, 0, 1, 1,   0, 0, 1, 0);
        add(1, 0, 0, 1, 1,   2, 1, 1, 1);
        add(1, 0, 0, 1, 0,   1, 0, 1, 1);
        add(1, 0, 0, 1, 0,   0, 0, 1, 0);
        add(1, 0, 0, 1, 0,   0, 1, 0, 1);
        run_table("autoreload");

        add(0, 4, 0, 1, 0,   4, 0, 0, 1);
        add(1, 0, 1, 1, 0,   4, 0, 1, 1);
        add(1, 0, 0, 1, 0,   3, 0, 1, 1);
        add(1, 0, 0, 1, 0,   2, 0, 1, 1);
        add(1, 0, 0, 0, 0,   2, 0, 1, 1);
        add(1, 0, 0, 0, 0,   2, 0, 1, 1);
        add(1, 0, 0, 0, 0,   2, 0, 1, 1);
        add(1, 0, 0, 1, 0,   1, 0, 1, 1);
        add(1, 0, 0, 1, 0,   0, 0, 1, 0);
        add(1, 0, 0, 1, 0,   0, 1, 0, 1);
        run_table("stall");

        add(0, 5, 0, 1, 0,   5, 0, 0, 1);
        add(1, 0, 1, 1, 0,   5, 0, 1, 1);
        add(1, 0, 0, 1, 0,   4, 0, 1, 1);
        add(0, 7, 1, 1, 0,   7, 0, 0, 1);
        add(1, 0, 1, 1, 0,   7, 0, 1, 1);
        add(1, 0, 0, 1, 0,   6, 0, 1, 1);
        add(1, 0, 1, 1, 0,   7, 0, 1, 1);
        run_table("collision");

        add(0, 0, 0, 1, 0,   0, 0, 0, 1);
        add(1, 0, 1, 1, 0,   0, 0, 1, 0);
        add(1, 0, 0, 1, 0,   0, 1, 0, 1);
        add(1, 0, 0, 1, 0,   0, 0, 0, 1);
        add(1, 0, 1, 1, 1,   0, 0, 1, 0);
        add(1, 0, 0, 1, 1,   0, 1, 1, 0);
        add(1, 0, 0, 1, 1,   0, 1, 1, 0);
        add(1, 0, 0, 0, 1,   0, 0, 1, 1);
        run_table("zero");

        // Abort a run at Q=5 with an asynchronous reset between clock edges.
        add(0, 8, 0, 1, 0,   8, 0, 0, 1);
        add(1, 0, 1, 1, 0,   8, 0, 1, 1);
        add(1, 0, 0, 1, 0,   7, 0, 1, 1);
        add(1, 0, 0, 1, 0,   6, 0, 1, 1);
        add(1, 0, 0, 1, 0,   5, 0, 1, 1);
        run_table("prereset");
        #2;
        RESET_n = 1'b0;
        #1;
        check("midrun reset Q",        32'(Q),        32'd0);
        check("midrun reset TC",       32'(TC),       32'd0);
        check("midrun reset BUSY",     32'(BUSY),     32'd0);
        check("midrun reset BORROW_n", 32'(BORROW_n), 32'd1);
        @(negedge CLK);
        RESET_n = 1'b1;

        // Idle after release, then START proves the reload register was cleared to 0.
        add(1, 0, 0, 1, 0,   0, 0, 0, 1);
        add(1, 0, 0, 1, 0,   0, 0, 0, 1);
        add(1, 0, 1, 1, 0,   0, 0, 1, 0);
        add(1, 0, 0, 1, 0,   0, 1, 0, 1);
        add(1, 0, 0, 1, 0,   0, 0, 0, 1);
        run_table("postreset");

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
